// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock controller.
//   state_t      : controller states
//   EMPTY_DIGIT  : value shown in an unfilled pin slot
//   STATUS_*     : encodings of the status output
//   timer_width  : bit width able to count up to the largest tick value
package lock_pkg;

    typedef enum logic [2:0] {
        LOCKED,
        ENTRY,
        CHECK,
        OPEN,
        LOCKOUT
    } state_t;

    localparam logic [3:0] EMPTY_DIGIT   = 4'hF;
    localparam logic       STATUS_LOCKED = 1'b0;
    localparam logic       STATUS_OPEN   = 1'b1;

    // Width for one counter shared by every timed state.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Clearable, saturating up-counter with a terminal-count compare.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   clear    in   restart the count from zero on the next edge
//   tc_value in   WIDTH  terminal-count value to compare against
//   tc       out  count currently equals tc_value
module tick_timer #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] tc_value,
    output logic             tc
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != COUNT_MAX) begin
            // Holds at all-ones instead of wrapping back to zero.
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == tc_value);

endmodule

// File: rtl/lock_controller.sv
// Keypad lock sequencer: collects four digits, checks them against the
// stored code, drives the lock status, produces tone pulses and enforces
// auto-relock, entry timeout and wrong-code lockout.
// Ports:
//   clk_500Hz  in   500 Hz system clock
//   rst        in   asynchronous active-high reset
//   key_valid  in   key_digit valid strobe
//   key_digit  in   4  digit 0-9 (10-15 ignored)
//   key_enter  in   submit the entry
//   key_clear  in   discard the partial entry
//   key_lock   in   relock while open
//   pin0..pin3 out  4 each  entered digits, 4'hF = empty
//   status     out  1 = open, 0 = locked
//   ok_pulse   out  one-cycle pulse on a correct code
//   err_pulse  out  one-cycle pulse on a wrong code / entering lockout
//   locked_out out  high during lockout
module lock_controller
    import lock_pkg::*;
#(
    parameter logic [15:0] DEFAULT_CODE  = 16'h1234,
    parameter int          OPEN_TICKS    = 2500,
    parameter int          ENTRY_TICKS   = 5000,
    parameter int          LOCKOUT_TICKS = 15000,
    parameter int          MAX_FAILS     = 3
) (
    input  logic       clk_500Hz,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_enter,
    input  logic       key_clear,
    input  logic       key_lock,
    output logic [3:0] pin0,
    output logic [3:0] pin1,
    output logic [3:0] pin2,
    output logic [3:0] pin3,
    output logic       status,
    output logic       ok_pulse,
    output logic       err_pulse,
    output logic       locked_out
);

    localparam int TW = timer_width(OPEN_TICKS, ENTRY_TICKS, LOCKOUT_TICKS);
    localparam int FW = $clog2(MAX_FAILS + 1);

    localparam logic [TW-1:0] OPEN_TC    = TW'(OPEN_TICKS - 1);
    localparam logic [TW-1:0] ENTRY_TC   = TW'(ENTRY_TICKS - 1);
    localparam logic [TW-1:0] LOCKOUT_TC = TW'(LOCKOUT_TICKS - 1);
    localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);

    state_t          state, state_next;
    logic [3:0]      pins [4];
    logic [3:0]      pins_next [4];
    logic [FW-1:0]   fail_cnt, fail_next;
    logic [15:0]     code;
    logic            ok_next, err_next;
    logic            restart;
    logic            timer_clear, timer_tc;
    logic [TW-1:0]   tc_value;
    logic            digit_event;
    logic            entry_full;
    logic [15:0]     entered_code;

    // Digits 10-15 are not treated as key events at all.
    assign digit_event  = key_valid && (key_digit <= 4'd9);
    assign entry_full   = (pins[3] != EMPTY_DIGIT);
    assign entered_code = {pins[0], pins[1], pins[2], pins[3]};

    // Each timed state compares the shared counter against its own limit.
    always_comb begin
        tc_value = '1;
        case (state)
            ENTRY:   tc_value = ENTRY_TC;
            OPEN:    tc_value = OPEN_TC;
            LOCKOUT: tc_value = LOCKOUT_TC;
            default: tc_value = '1;
        endcase
    end

    // The timer restarts on every state change and on each accepted digit.
    assign timer_clear = restart || (state_next != state);

    tick_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk      (clk_500Hz),
        .rst      (rst),
        .clear    (timer_clear),
        .tc_value (tc_value),
        .tc       (timer_tc)
    );

    // NOTE: every signal written here gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        pins_next  = pins;
        fail_next  = fail_cnt;
        ok_next    = 1'b0;
        err_next   = 1'b0;
        restart    = 1'b0;

        case (state)
            LOCKED: begin
                // A clear in the same cycle swallows the digit.
                if (!key_clear && digit_event) begin
                    pins_next[0] = key_digit;
                    state_next   = ENTRY;
                end
            end

            ENTRY: begin
                if (key_clear) begin
                    pins_next  = '{default: EMPTY_DIGIT};
                    state_next = LOCKED;
                end else if (digit_event) begin
                    // pin0 is always filled here; a digit past the fourth is dropped.
                    if (!entry_full) begin
                        restart = 1'b1;
                        if (pins[1] == EMPTY_DIGIT)      pins_next[1] = key_digit;
                        else if (pins[2] == EMPTY_DIGIT) pins_next[2] = key_digit;
                        else                             pins_next[3] = key_digit;
                    end
                end else if (key_enter && entry_full) begin
                    state_next = CHECK;
                end else if (timer_tc) begin
                    pins_next  = '{default: EMPTY_DIGIT};
                    state_next = LOCKED;
                end
            end

            CHECK: begin
                pins_next = '{default: EMPTY_DIGIT};
                if (entered_code == code) begin
                    ok_next    = 1'b1;
                    fail_next  = '0;
                    state_next = OPEN;
                end else begin
                    err_next   = 1'b1;
                    fail_next  = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + FW'(1);
                    state_next = (fail_next == FAIL_LIMIT) ? LOCKOUT : LOCKED;
                end
            end

            OPEN: begin
                if (key_lock || timer_tc) begin
                    state_next = LOCKED;
                end
            end

            LOCKOUT: begin
                if (timer_tc) begin
                    fail_next  = '0;
                    state_next = LOCKED;
                end
            end

            default: begin
                pins_next  = '{default: EMPTY_DIGIT};
                state_next = LOCKED;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so each key event
    // shows up exactly one edge later.
    always_ff @(posedge clk_500Hz or posedge rst) begin
        if (rst) begin
            state      <= LOCKED;
            // NOTE: the pin slots are reset explicitly because an empty slot
            // must read 4'hF, not an arbitrary power-up value.
            pins       <= '{default: EMPTY_DIGIT};
            fail_cnt   <= '0;
            code       <= DEFAULT_CODE;
            status     <= STATUS_LOCKED;
            ok_pulse   <= 1'b0;
            err_pulse  <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_next;
            pins       <= pins_next;
            fail_cnt   <= fail_next;
            status     <= (state_next == OPEN) ? STATUS_OPEN : STATUS_LOCKED;
            ok_pulse   <= ok_next;
            err_pulse  <= err_next;
            locked_out <= (state_next == LOCKOUT);
        end
    end

    assign pin0 = pins[0];
    assign pin1 = pins[1];
    assign pin2 = pins[2];
    assign pin3 = pins[3];

endmodule

// File: tb/tb_lock_controller.sv
// Scenario bench for lock_controller: expected outputs are queued when a
// stimulus cycle is driven, the DUT outputs are queued after the edge, and
// each scenario task compares the two queues.
module tb_lock_controller;

    localparam int OPEN_TICKS    = 2500;
    localparam int ENTRY_TICKS   = 5000;
    localparam int LOCKOUT_TICKS = 15000;

    logic       clk_500Hz = 1'b0;
    logic       rst       = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       key_enter = 1'b0;
    logic       key_clear = 1'b0;
    logic       key_lock  = 1'b0;
    logic [3:0] pin0, pin1, pin2, pin3;
    logic       status, ok_pulse, err_pulse, locked_out;

    int vectors     = 0;
    int miscompares = 0;

    string       tag_q[$];
    logic [19:0] exp_q[$];
    logic [19:0] act_q[$];

    lock_controller #(
        .DEFAULT_CODE  (16'h1234),
        .OPEN_TICKS    (OPEN_TICKS),
        .ENTRY_TICKS   (ENTRY_TICKS),
        .LOCKOUT_TICKS (LOCKOUT_TICKS),
        .MAX_FAILS     (3)
    ) dut (
        .clk_500Hz  (clk_500Hz),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_enter  (key_enter),
        .key_clear  (key_clear),
        .key_lock   (key_lock),
        .pin0       (pin0),
        .pin1       (pin1),
        .pin2       (pin2),
        .pin3       (pin3),
        .status     (status),
        .ok_pulse   (ok_pulse),
        .err_pulse  (err_pulse),
        .locked_out (locked_out)
    );

    always #5 clk_500Hz = ~clk_500Hz;

    // {pins, status, ok, err, locked_out}
    function automatic logic [19:0] o(input logic [15:0] p, input logic st,
                                      input logic ok, input logic er, input logic lo);
        return {p, st, ok, er, lo};
    endfunction

    function automatic logic [19:0] dut_out();
        return {pin0, pin1, pin2, pin3, status, ok_pulse, err_pulse, locked_out};
    endfunction

    // One clock of stimulus; inputs return to idle just after the edge.
    task automatic drive(input logic v, input logic [3:0] d, input logic e,
                         input logic c, input logic l);
        key_valid = v;
        key_digit = d;
        key_enter = e;
        key_clear = c;
        key_lock  = l;
        @(posedge clk_500Hz);
        #1;
        key_valid = 1'b0;
        key_digit = 4'd0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        key_lock  = 1'b0;
    endtask

    task automatic step(input string tag, input logic v, input logic [3:0] d,
                        input logic e, input logic c, input logic l, input logic [19:0] ev);
        tag_q.push_back(tag);
        exp_q.push_back(ev);
        drive(v, d, e, c, l);
        act_q.push_back(dut_out());
    endtask

    task automatic watch(input string tag, input logic [19:0] ev);
        step(tag, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, ev);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [15:0] c);
        drive(1'b1, c[15:12], 1'b0, 1'b0, 1'b0);
        drive(1'b1, c[11:8],  1'b0, 1'b0, 1'b0);
        drive(1'b1, c[7:4],   1'b0, 1'b0, 1'b0);
        drive(1'b1, c[3:0],   1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0,     1'b1, 1'b0, 1'b0);
    endtask

    // Queue an expectation for the outputs right now (used around async reset).
    task automatic sample_now(input string tag, input logic [19:0] ev);
        tag_q.push_back(tag);
        exp_q.push_back(ev);
        act_q.push_back(dut_out());
    endtask

    task automatic test_reset();
        string tag; logic [19:0] want, got;
        rst = 1'b1;
        repeat (2) @(posedge clk_500Hz);
        #1;
        sample_now("reset_hold", o(16'hFFFF, 0, 0, 0, 0));
        rst = 1'b0;
        watch("reset_release", o(16'hFFFF, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            tag = tag_q.pop_front(); want = exp_q.pop_front(); got = act_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s: got pins=%h st/ok/err/lo=%b, want pins=%h st/ok/err/lo=%b",
                         tag, got[19:4], got[3:0], want[19:4], want[3:0]);
            end
        end
    endtask

    task automatic test_correct_code();
        string tag; logic [19:0] want, got;
        step("digit_1", 1, 4'd1, 0, 0, 0, o(16'h1FFF, 0, 0, 0, 0));
        step("digit_2", 1, 4'd2, 0, 0, 0, o(16'h12FF, 0, 0, 0, 0));
        step("digit_3", 1, 4'd3, 0, 0, 0, o(16'h123F, 0, 0, 0, 0));
        step("digit_4", 1, 4'd4, 0, 0, 0, o(16'h1234, 0, 0, 0, 0));
        step("enter_to_check", 0, 4'd0, 1, 0, 0, o(16'h1234, 0, 0, 0, 0));
        watch("ok_pulse", o(16'hFFFF, 1, 1, 0, 0));
        watch("open_hold", o(16'hFFFF, 1, 0, 0, 0));
        step("manual_relock", 0, 4'd0, 0, 0, 1, o(16'hFFFF, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            tag = tag_q.pop_front(); want = exp_q.pop_front(); got = act_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s: got pins=%h st/ok/err/lo=%b, want pins=%h st/ok/err/lo=%b",
                         tag, got[19:4], got[3:0], want[19:4], want[3:0]);
            end
        end
    endtask

    task automatic test_open_timeout();
        string tag; logic [19:0] want, got;
        enter_code(16'h1234);
        watch("open_entry", o(16'hFFFF, 1, 1, 0, 0));
        step("open_digit_ignored", 1, 4'd5, 0, 0, 0, o(16'hFFFF, 1, 0, 0, 0));
        idle(OPEN_TICKS - 3);
        watch("open_last_cycle", o(16'hFFFF, 1, 0, 0, 0));
        watch("auto_relock", o(16'hFFFF, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            tag = tag_q.pop_front(); want = exp_q.pop_front(); got = act_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s: got pins=%h st/ok/err/lo=%b, want pins=%h st/ok/err/lo=%b",
                         tag, got[19:4], got[3:0], want[19:4], want[3:0]);
            end
        end
    endtask

    task automatic test_key_lock();
        string tag; logic [19:0] want, got;
        enter_code(16'h1234);
        watch("lock_open_entry", o(16'hFFFF, 1, 1, 0, 0));
        idle(8);
        watch("lock_still_open", o(16'hFFFF, 1, 0, 0, 0));
        step("key_lock_relock", 0, 4'd0, 0, 0, 1, o(16'hFFFF, 0, 0, 0, 0));
        step("key_lock_when_locked", 0, 4'd0, 0, 0, 1, o(16'hFFFF, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            tag = tag_q.pop_front(); want = exp_q.pop_front(); got = act_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s: got pins=%h st/ok/err/lo=%b, want pins=%h st/ok/err/lo=%b",
                         tag, got[19:4], got[3:0], want[19:4], want[3:0]);
            end
        end
    endtask

    task automatic test_lockout();
        string tag; logic [19:0] want, got;
        for (int i = 0; i < 3; i++) begin
            enter_code(16'h9999);
            watch($sformatf("wrong_code_%0d", i), o(16'hFFFF, 0, 0, 1, (i == 2)));
        end
        step("lockout_digit_1", 1, 4'd1, 0, 0, 0, o(16'hFFFF, 0, 0, 0, 1));
        step("lockout_digit_2", 1, 4'd2, 0, 0, 0, o(16'hFFFF, 0, 0, 0, 1));
        step("lockout_digit_3", 1, 4'd3, 0, 0, 0, o(16'hFFFF, 0, 0, 0, 1));
        step("lockout_digit_4", 1, 4'd4, 0, 0, 0, o(16'hFFFF, 0, 0, 0, 1));
        step("lockout_enter", 0, 4'd0, 1, 0, 0, o(16'hFFFF, 0, 0, 0, 1));
        watch("lockout_no_ok", o(16'hFFFF, 0, 0, 0, 1));
        idle(LOCKOUT_TICKS - 8);
        watch("lockout_last_cycle", o(16'hFFFF, 0, 0, 0, 1));
        watch("lockout_exit", o(16'hFFFF, 0, 0, 0, 0));
        enter_code(16'h1234);
        watch("open_after_lockout", o(16'hFFFF, 1, 1, 0, 0));
        drive(0, 4'd0, 0, 0, 1);
        while (exp_q.size() > 0) begin
            tag = tag_q.pop_front(); want = exp_q.pop_front(); got = act_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s: got pins=%h st/ok/err/lo=%b, want pins=%h st/ok/err/lo=%b",
                         tag, got[19:4], got[3:0], want[19:4], want[3:0]);
            end
        end
    endtask

    task automatic test_clear_timeout();
        string tag; logic [19:0] want, got;
        step("clr_digit_5", 1, 4'd5, 0, 0, 0, o(16'h5FFF, 0, 0, 0, 0));
        step("clr_digit_6", 1, 4'd6, 0, 0, 0, o(16'h56FF, 0, 0, 0, 0));
        step("key_clear", 0, 4'd0, 0, 1, 0, o(16'hFFFF, 0, 0, 0, 0));
        // Back in LOCKED, the next digit lands in pin0 again.
        step("after_clear_digit", 1, 4'd7, 0, 0, 0, o(16'h7FFF, 0, 0, 0, 0));
        drive(0, 4'd0, 0, 1, 0);
        drive(1, 4'd5, 0, 0, 0);
        step("timeout_digit_6", 1, 4'd6, 0, 0, 0, o(16'h56FF, 0, 0, 0, 0));
        idle(ENTRY_TICKS - 2);
        watch("entry_last_cycle", o(16'h56FF, 0, 0, 0, 0));
        watch("entry_timeout", o(16'hFFFF, 0, 0, 0, 0));
        step("short_digit_5", 1, 4'd5, 0, 0, 0, o(16'h5FFF, 0, 0, 0, 0));
        step("short_digit_6", 1, 4'd6, 0, 0, 0, o(16'h56FF, 0, 0, 0, 0));
        step("short_enter", 0, 4'd0, 1, 0, 0, o(16'h56FF, 0, 0, 0, 0));
        watch("short_enter_no_pulse", o(16'h56FF, 0, 0, 0, 0));
        drive(0, 4'd0, 0, 1, 0);
        while (exp_q.size() > 0) begin
            tag = tag_q.pop_front(); want = exp_q.pop_front(); got = act_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s: got pins=%h st/ok/err/lo=%b, want pins=%h st/ok/err/lo=%b",
                         tag, got[19:4], got[3:0], want[19:4], want[3:0]);
            end
        end
    endtask

    task automatic test_priority();
        string tag; logic [19:0] want, got;
        step("clear_beats_digit_locked", 1, 4'd7, 0, 1, 0, o(16'hFFFF, 0, 0, 0, 0));
        step("digit_12_locked", 1, 4'd12, 0, 0, 0, o(16'hFFFF, 0, 0, 0, 0));
        step("prio_digit_1", 1, 4'd1, 0, 0, 0, o(16'h1FFF, 0, 0, 0, 0));
        step("digit_12_entry", 1, 4'd12, 0, 0, 0, o(16'h1FFF, 0, 0, 0, 0));
        step("clear_beats_digit_entry", 1, 4'd7, 0, 1, 0, o(16'hFFFF, 0, 0, 0, 0));
        drive(1, 4'd1, 0, 0, 0);
        drive(1, 4'd2, 0, 0, 0);
        drive(1, 4'd3, 0, 0, 0);
        step("prio_digit_4", 1, 4'd4, 0, 0, 0, o(16'h1234, 0, 0, 0, 0));
        step("fifth_digit", 1, 4'd5, 0, 0, 0, o(16'h1234, 0, 0, 0, 0));
        step("prio_enter", 0, 4'd0, 1, 0, 0, o(16'h1234, 0, 0, 0, 0));
        watch("prio_ok", o(16'hFFFF, 1, 1, 0, 0));
        drive(0, 4'd0, 0, 0, 1);
        while (exp_q.size() > 0) begin
            tag = tag_q.pop_front(); want = exp_q.pop_front(); got = act_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s: got pins=%h st/ok/err/lo=%b, want pins=%h st/ok/err/lo=%b",
                         tag, got[19:4], got[3:0], want[19:4], want[3:0]);
            end
        end
    endtask

    task automatic test_reset_midway();
        string tag; logic [19:0] want, got;
        // Reset while locked out.
        for (int i = 0; i < 3; i++) begin
            enter_code(16'h9999);
            watch($sformatf("mid_a_fail_%0d", i), o(16'hFFFF, 0, 0, 1, (i == 2)));
        end
        idle(20);
        #2 rst = 1'b1;
        #1 sample_now("rst_in_lockout", o(16'hFFFF, 0, 0, 0, 0));
        @(posedge clk_500Hz);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enter_code(16'h9999);
            watch($sformatf("after_lockout_rst_fail_%0d", i), o(16'hFFFF, 0, 0, 1, (i == 2)));
        end
        #2 rst = 1'b1;
        @(posedge clk_500Hz);
        #1 rst = 1'b0;
        // Two misses, then reset while the third code is in CHECK.
        for (int i = 0; i < 2; i++) begin
            enter_code(16'h9999);
            watch($sformatf("mid_b_fail_%0d", i), o(16'hFFFF, 0, 0, 1, 0));
        end
        enter_code(16'h9999);
        #2 rst = 1'b1;
        #1 sample_now("rst_in_check", o(16'hFFFF, 0, 0, 0, 0));
        @(posedge clk_500Hz);
        #1 sample_now("rst_check_no_pulse", o(16'hFFFF, 0, 0, 0, 0));
        rst = 1'b0;
        watch("after_check_rst_idle", o(16'hFFFF, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            enter_code(16'h9999);
            watch($sformatf("after_check_rst_fail_%0d", i), o(16'hFFFF, 0, 0, 1, (i == 2)));
        end
        #2 rst = 1'b1;
        @(posedge clk_500Hz);
        #1 rst = 1'b0;
        while (exp_q.size() > 0) begin
            tag = tag_q.pop_front(); want = exp_q.pop_front(); got = act_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s: got pins=%h st/ok/err/lo=%b, want pins=%h st/ok/err/lo=%b",
                         tag, got[19:4], got[3:0], want[19:4], want[3:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_correct_code();
        test_open_timeout();
        test_key_lock();
        test_lockout();
        test_clear_timeout();
        test_priority();
        test_reset_midway();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lock_controller.md
Name: lock_controller

Overview:
- Sequences the keypad lock. Accepts debounced key events and builds the 4-digit entry (pin0..pin3) that the 7-seg output block renders. Checks the entry against the stored code and drives the lock status.
- Also produces one-cycle tone pulses for the audio path, and enforces auto-relock, entry timeout and a wrong-code lockout.
- Sits between the keypad decoder and the display/audio output block, on the same 500 Hz clock.

Parameters:
- DEFAULT_CODE, 16'h1234, code loaded at reset, {pin0,pin1,pin2,pin3} nibble order.
- OPEN_TICKS, 2500, clk_500Hz cycles spent OPEN before auto-relock (5 s).
- ENTRY_TICKS, 5000, idle cycles in ENTRY before the partial entry is discarded (10 s).
- LOCKOUT_TICKS, 15000, cycles of lockout after MAX_FAILS consecutive wrong codes (30 s).
- MAX_FAILS, 3, consecutive mismatches that trigger lockout.

Ports:
- clk_500Hz  in  1  system clock, 500 Hz.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe: key_digit is valid this cycle.
- key_digit  in  4  digit 0-9; values 10-15 ignored.
- key_enter  in  1  one-cycle strobe: submit the entry.
- key_clear  in  1  one-cycle strobe: discard the partial entry.
- key_lock  in  1  one-cycle strobe: relock immediately while OPEN.
- pin0..pin3  out  4 each  entered digits; 4'hF = empty slot.
- status  out  1  1 = open, 0 = locked.
- ok_pulse  out  1  one-cycle pulse on a correct code.
- err_pulse  out  1  one-cycle pulse on a wrong code or on entering lockout.
- locked_out  out  1  high while in LOCKOUT.

Behaviour:
- Reset (async assert, sync release): state LOCKED, pin0..3=4'hF, status=0, ok/err_pulse=0, locked_out=0, fail_cnt=0, timer=0, code=DEFAULT_CODE.
- All outputs are registered. Each key event takes effect on the next edge (1-cycle latency).
- Same-cycle priority: key_clear > key_valid > key_enter. Lower-priority events in that cycle are dropped.
- LOCKED:
  - Valid digit: write it to pin0, go to ENTRY, timer=0.
  - key_enter, key_clear, key_lock: no effect.
- ENTRY:
  - Valid digit fills the lowest empty slot (pin1, pin2, then pin3), timer=0.
  - Digits arriving with all 4 slots full are ignored.
  - key_clear: all pins=F, go to LOCKED.
  - key_enter with fewer than 4 digits: ignored.
  - key_enter with 4 digits: go to CHECK.
  - timer reaching ENTRY_TICKS-1 with no key: pins=F, go to LOCKED.
- CHECK (exactly 1 cycle): compare {pin0,pin1,pin2,pin3} to code; pins=F on exit.
  - Match: ok_pulse, fail_cnt=0, go to OPEN, status=1, timer=0.
  - Mismatch: err_pulse, fail_cnt+1. If the new fail_cnt equals MAX_FAILS, go to LOCKOUT (locked_out=1, timer=0); otherwise go to LOCKED.
- OPEN:
  - status=1; digits, enter and clear are ignored.
  - key_lock, or timer reaching OPEN_TICKS-1: status=0, go to LOCKED.
  - If both happen in the same cycle, the result is the same single transition.
- LOCKOUT:
  - All keys ignored; pins stay F; status=0.
  - When timer reaches LOCKOUT_TICKS-1: fail_cnt=0, locked_out=0, go to LOCKED.
- Timer:
  - One shared counter, cleared on every state entry.
  - Sized clog2 of the largest *_TICKS value; saturates and never wraps.
- fail_cnt:
  - Saturates at MAX_FAILS.
  - Cleared only by a correct code or by leaving LOCKOUT.
  - Not cleared by key_clear or entry timeout.
- Reset mid-operation (any state, including CHECK or LOCKOUT): immediate return to reset values; pulses are never stretched.
- ok_pulse and err_pulse are never high in the same cycle and are high for exactly one cycle per event.

Decomposition:
- lock_pkg holds:
  - state enum {LOCKED, ENTRY, CHECK, OPEN, LOCKOUT}
  - EMPTY_DIGIT=4'hF
  - STATUS_LOCKED/STATUS_OPEN
  - the timer-width function
- Sub-module tick_timer: clearable, saturating up-counter with a terminal-count compare input; one instance shared across states.

Test Plan:
- Reset, then digits 1,2,3,4 and enter: pins read 1,F,F,F -> 1,2,F,F -> ... -> 1,2,3,4. One cycle after enter, ok_pulse=1; next cycle status=1 and pins=F.
- In OPEN, idle: status falls exactly OPEN_TICKS cycles after entry. Second run: key_lock at cycle 10 relocks on the next edge.
- Enter 9,9,9,9 three times: err_pulse three times. After the third, locked_out=1; the correct code entered during lockout is ignored. locked_out clears after LOCKOUT_TICKS, then 1234 opens.
- Digits 5,6 then key_clear: pins return to F/F/F/F and state is LOCKED. Digits 5,6 then idle ENTRY_TICKS: same result. Enter with 2 digits: no pulse.
- key_valid(7) together with key_clear in one cycle: clear wins, pins=F. Fifth digit after 4: ignored. key_digit=12: ignored.
- Assert rst during LOCKOUT and during CHECK: all outputs return to reset values asynchronously; fail_cnt=0, verified by needing 3 new fails to re-lockout.
